// File: rtl/timer_phase_seq_if.sv
// timer_phase_seq_if: start/abort/lengths in, timer enable/ready, and sequence status of the phase sequencer
interface timer_phase_seq_if #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W = 2,
  parameter int LEN_W = 4
);
  logic start;
  logic abort;
  logic [NUM_PHASES*LEN_W-1:0] phase_len;
  logic ready;
  logic en_timer;
  logic busy;
  logic [PHASE_W-1:0] phase;
  logic phase_strobe;
  logic done;
  logic err;
  modport master (
    output start, abort, phase_len, ready,
    input en_timer, busy, phase, phase_strobe, done, err
  );
  modport slave (
    input start, abort, phase_len, ready,
    output en_timer, busy, phase, phase_strobe, done, err
  );
endinterface

// File: rtl/timer_phase_seq.sv
// timer_phase_seq: runs a cable test through timed phases, each a programmed number of timer ready ticks, with a watchdog
module timer_phase_seq #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_W = 2,
  parameter int LEN_W = 4,
  parameter int WDOG_CYC = 16
) (
  input logic clk,
  input logic reset,
  timer_phase_seq_if.slave s
);
  localparam int WD_W = $clog2(WDOG_CYC);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t r_state;
  logic [NUM_PHASES*LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [WD_W-1:0] r_wd;
  logic [PHASE_W-1:0] r_phase;
  logic r_en;
  logic r_busy;
  logic r_strobe;
  logic r_done;
  logic r_err;
  logic [PHASE_W-1:0] w_first;
  logic [PHASE_W-1:0] w_next;
  logic [LEN_W-1:0] w_len;
  logic w_first_ok;
  logic w_next_ok;
  logic w_tick;
  logic w_last;
  logic w_wdog;
  assign w_tick = s.ready & r_en;
  assign w_last = r_cnt == w_len - 1'b1;
  assign w_wdog = r_wd == WD_W'(WDOG_CYC - 1);
  // Lowest nonzero incoming field, next nonzero latched field above the active phase, and active phase length
  always_comb begin
    w_first_ok = 1'b0;
    w_first = '0;
    w_next_ok = 1'b0;
    w_next = '0;
    w_len = '0;
    for (int k = NUM_PHASES - 1; k >= 0; k--) begin
      if (s.phase_len[k*LEN_W +: LEN_W] != '0) begin
        w_first_ok = 1'b1;
        w_first = PHASE_W'(k);
      end
      if (PHASE_W'(k) > r_phase && r_len[k*LEN_W +: LEN_W] != '0) begin
        w_next_ok = 1'b1;
        w_next = PHASE_W'(k);
      end
      if (PHASE_W'(k) == r_phase) w_len = r_len[k*LEN_W +: LEN_W];
    end
  end
  // Sequencer: abort beats a phase-ending tick, which beats watchdog expiry; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_len <= '0;
      r_cnt <= '0;
      r_wd <= '0;
      r_phase <= '0;
      r_en <= 1'b0;
      r_busy <= 1'b0;
      r_strobe <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (s.start) begin
          r_len <= s.phase_len;
          r_err <= 1'b0;
          r_cnt <= '0;
          r_wd <= '0;
          r_state <= w_first_ok ? RUN : FIN;
          r_en <= w_first_ok;
          r_busy <= w_first_ok;
          r_strobe <= w_first_ok;
          r_phase <= w_first_ok ? w_first : r_phase;
        end
        RUN: if (s.abort) begin
          r_state <= IDLE;
          r_en <= 1'b0;
          r_busy <= 1'b0;
        end else if (w_tick && w_last) begin
          r_cnt <= '0;
          r_wd <= '0;
          r_phase <= w_next_ok ? w_next : r_phase;
          r_strobe <= w_next_ok;
          r_state <= w_next_ok ? RUN : FIN;
          r_en <= w_next_ok;
          r_busy <= w_next_ok;
        end else if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
          r_wd <= '0;
        end else if (w_wdog) begin
          r_state <= IDLE;
          r_en <= 1'b0;
          r_busy <= 1'b0;
          r_err <= 1'b1;
        end else begin
          r_wd <= r_wd + 1'b1;
        end
        FIN: begin
          r_done <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign s.en_timer = r_en;
  assign s.busy = r_busy;
  assign s.phase = r_phase;
  assign s.phase_strobe = r_strobe;
  assign s.done = r_done;
  assign s.err = r_err;
endmodule

// File: tb/tb_timer_phase_seq.sv
// tb_timer_phase_seq: directed scenarios against an 8-count timer model, checked by an event/snapshot scoreboard
module tb_timer_phase_seq;
  localparam int K_ST = 0;
  localparam int K_ERR = 1;
  localparam int K_HALT = 2;
  localparam int K_DONE = 3;
  typedef struct {int kind; int cyc; int ph;} ev_t;
  typedef struct {int cyc; logic [6:0] v;} sn_t;
  logic clk = 1'b0;
  logic reset;
  logic tclr;
  logic rdy_kill;
  logic [2:0] tcnt;
  int cyc = 0;
  int chk = 0;
  int pass = 0;
  logic end_flag = 1'b0;
  logic flushed = 1'b0;
  ev_t ev_q[$];
  sn_t sn_q[$];
  timer_phase_seq_if #(.NUM_PHASES(4), .PHASE_W(2), .LEN_W(4)) bus();
  timer_phase_seq #(.NUM_PHASES(4), .PHASE_W(2), .LEN_W(4), .WDOG_CYC(16)) dut (
    .clk(clk),
    .reset(reset),
    .s(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tcnt <= (reset || tclr) ? 3'd0 : tcnt + {2'b00, bus.en_timer};
  assign bus.ready = bus.en_timer && tcnt == 3'd7 && !rdy_kill;
  task automatic ev(input int k, input int c, input int p);
    ev_t e;
    e.kind = k;
    e.cyc = c;
    e.ph = p;
    ev_q.push_back(e);
  endtask
  task automatic sn(input int c, input logic [4:0] f, input logic [1:0] p);
    sn_t x;
    x.cyc = c;
    x.v = {f, p};
    sn_q.push_back(x);
  endtask
  task automatic tick_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic kick(input logic [15:0] l, output int s);
    bus.phase_len = l;
    bus.start = 1'b1;
    s = cyc + 1;
    tick_to(cyc + 1);
    bus.start = 1'b0;
  endtask
  task automatic clr();
    tclr = 1'b1;
    tick_to(cyc + 1);
    tclr = 1'b0;
  endtask
  task automatic exp_full(input int s);
    ev(K_ST, s, 0);
    ev(K_ST, s + 24, 1);
    ev(K_ST, s + 32, 2);
    ev(K_ST, s + 48, 3);
    ev(K_HALT, s + 56, 3);
    ev(K_DONE, s + 57, 3);
    sn(s, 5'b11100, 0);
    sn(s + 23, 5'b11000, 0);
    sn(s + 24, 5'b11100, 1);
    sn(s + 55, 5'b11000, 3);
    sn(s + 56, 5'b00000, 3);
    sn(s + 57, 5'b00010, 3);
    sn(s + 58, 5'b00000, 3);
  endtask
  task automatic chk_ev(input int k);
    ev_t e;
    chk++;
    if (ev_q.size() == 0) begin
      $display("FAIL event: got kind=%0d cyc=%0d phase=%0d, required none", k, cyc, bus.phase);
    end else begin
      e = ev_q.pop_front();
      if (e.kind == k && e.cyc == cyc && e.ph == int'(bus.phase)) pass++;
      else $display("FAIL event: got kind=%0d cyc=%0d phase=%0d, required kind=%0d cyc=%0d phase=%0d", k, cyc, bus.phase, e.kind, e.cyc, e.ph);
    end
  endtask
  initial begin
    logic pb;
    logic pe;
    logic [6:0] got;
    sn_t x;
    pb = 1'b0;
    pe = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.phase_strobe === 1'b1) chk_ev(K_ST);
      if (bus.err === 1'b1 && pe !== 1'b1) chk_ev(K_ERR);
      if (bus.busy === 1'b0 && pb === 1'b1) chk_ev(K_HALT);
      if (bus.done === 1'b1) chk_ev(K_DONE);
      got = {bus.en_timer, bus.busy, bus.phase_strobe, bus.done, bus.err, bus.phase};
      while (sn_q.size() > 0 && sn_q[0].cyc <= cyc) begin
        x = sn_q.pop_front();
        chk++;
        if (x.cyc == cyc && got === x.v) pass++;
        else $display("FAIL snap@%0d: got {en,busy,strb,done,err,ph}=%b at cyc %0d, required %b", x.cyc, got, cyc, x.v);
      end
      pb = bus.busy;
      pe = bus.err;
      if (end_flag && !flushed) begin
        while (ev_q.size() > 0) begin
          chk++;
          $display("FAIL missing event: got none, required kind=%0d cyc=%0d phase=%0d", ev_q[0].kind, ev_q[0].cyc, ev_q[0].ph);
          void'(ev_q.pop_front());
        end
        while (sn_q.size() > 0) begin
          chk++;
          $display("FAIL missing snap: got none, required %b at cyc %0d", sn_q[0].v, sn_q[0].cyc);
          void'(sn_q.pop_front());
        end
        flushed = 1'b1;
      end
    end
  end
  initial begin
    int s;
    reset = 1'b1;
    tclr = 1'b0;
    rdy_kill = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.phase_len = '0;
    sn(1, 5'b00000, 0);
    sn(2, 5'b00000, 0);
    sn(3, 5'b00000, 0);
    sn(4, 5'b00000, 0);
    tick_to(3);
    reset = 1'b0;
    tick_to(4);
    kick(16'h1213, s);
    exp_full(s);
    tick_to(s + 60);
    kick(16'h0200, s);
    ev(K_ST, s, 2);
    ev(K_HALT, s + 16, 2);
    ev(K_DONE, s + 17, 2);
    sn(s + 15, 5'b11000, 2);
    sn(s + 16, 5'b00000, 2);
    tick_to(s + 20);
    kick(16'h0000, s);
    ev(K_DONE, s + 1, 2);
    sn(s, 5'b00000, 2);
    sn(s + 1, 5'b00010, 2);
    sn(s + 2, 5'b00000, 2);
    tick_to(s + 4);
    clr();
    rdy_kill = 1'b1;
    kick(16'h0001, s);
    ev(K_ST, s, 0);
    ev(K_ERR, s + 16, 0);
    ev(K_HALT, s + 16, 0);
    sn(s + 15, 5'b11000, 0);
    sn(s + 16, 5'b00001, 0);
    sn(s + 20, 5'b00001, 0);
    tick_to(s + 21);
    rdy_kill = 1'b0;
    clr();
    kick(16'h0001, s);
    ev(K_ST, s, 0);
    ev(K_HALT, s + 8, 0);
    ev(K_DONE, s + 9, 0);
    sn(s, 5'b11100, 0);
    tick_to(s + 12);
    clr();
    kick(16'h0021, s);
    ev(K_ST, s, 0);
    ev(K_ST, s + 8, 1);
    ev(K_HALT, s + 24, 1);
    sn(s + 23, 5'b11000, 1);
    sn(s + 24, 5'b00000, 1);
    sn(s + 25, 5'b00000, 1);
    tick_to(s + 23);
    bus.abort = 1'b1;
    tick_to(s + 24);
    bus.abort = 1'b0;
    tick_to(s + 28);
    clr();
    kick(16'h0011, s);
    ev(K_ST, s, 0);
    ev(K_ST, s + 8, 1);
    ev(K_HALT, s + 16, 1);
    ev(K_DONE, s + 17, 1);
    sn(s + 16, 5'b00000, 1);
    sn(s + 17, 5'b00010, 1);
    sn(s + 18, 5'b00000, 1);
    tick_to(s + 3);
    bus.phase_len = 16'hFFFF;
    bus.start = 1'b1;
    tick_to(s + 4);
    bus.start = 1'b0;
    tick_to(s + 10);
    bus.start = 1'b1;
    tick_to(s + 11);
    bus.start = 1'b0;
    tick_to(s + 16);
    bus.start = 1'b1;
    tick_to(s + 17);
    bus.start = 1'b0;
    tick_to(s + 20);
    clr();
    kick(16'h1211, s);
    ev(K_ST, s, 0);
    ev(K_ST, s + 8, 1);
    ev(K_ST, s + 16, 2);
    ev(K_HALT, s + 21, 0);
    sn(s + 20, 5'b11000, 2);
    sn(s + 21, 5'b00000, 0);
    sn(s + 22, 5'b00000, 0);
    tick_to(s + 20);
    reset = 1'b1;
    tick_to(s + 21);
    reset = 1'b0;
    tick_to(s + 23);
    kick(16'h1213, s);
    exp_full(s);
    tick_to(s + 62);
    end_flag = 1'b1;
    repeat (3) @(posedge clk);
    if (!flushed) begin
      chk++;
      $display("FAIL flush: got none, required scoreboard drain");
    end
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
